// File: rtl/timestamp_snapshot_sequencer_pkg.sv
// Shared types and timer register map for the timestamp snapshot sequencer.
package timestamp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        SNAP_WR,
        SNAP_RD,
        IRQ_ACK
    } seq_state_t;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CONTROL = 4'd1;
    localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
    localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
    localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
    localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
    localparam logic [3:0] ADDR_SNAP0   = 4'd6;
    localparam logic [3:0] ADDR_SNAP1   = 4'd7;
    localparam logic [3:0] ADDR_SNAP2   = 4'd8;
    localparam logic [3:0] ADDR_SNAP3   = 4'd9;

    // Cycles from acceptance edge to the snap_valid cycle
    localparam int SNAP_LATENCY = 7;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [3:0]  addr;
        logic [15:0] data;
    } tmr_cmd_t;

    localparam tmr_cmd_t TMR_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 4'd0, data: 16'd0};

endpackage

// File: rtl/timestamp_snapshot_sequencer_if.sv
// Requester, configuration and timer-bus signals of the timestamp snapshot sequencer.
interface timestamp_snapshot_sequencer_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       snap_valid;
    logic [$clog2(NUM_REQ)-1:0] snap_id;
    logic [63:0]                snap_value;
    logic                       cfg_valid;
    logic [63:0]                cfg_period;
    logic [3:0]                 cfg_ctrl;
    logic                       cfg_ready;
    logic [3:0]                 tmr_address;
    logic                       tmr_chipselect;
    logic                       tmr_write_n;
    logic [15:0]                tmr_writedata;
    logic [15:0]                tmr_readdata;
    logic                       tmr_irq;
    logic                       irq_event;
    logic                       busy;

    modport master (
        input  req_valid, cfg_valid, cfg_period, cfg_ctrl, tmr_readdata, tmr_irq,
        output req_ready, snap_valid, snap_id, snap_value, cfg_ready,
               tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, irq_event, busy
    );

    modport slave (
        output req_valid, cfg_valid, cfg_period, cfg_ctrl, tmr_readdata, tmr_irq,
        input  req_ready, snap_valid, snap_id, snap_value, cfg_ready,
               tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, irq_event, busy
    );

endinterface

// File: rtl/timestamp_snapshot_sequencer_rr_arbiter.sv
// Round-robin selector: one-hot grant, priority starts just after the last advanced grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]        ptr, ptr_nxt;
    logic [NUM_REQ-1:0]   rot, rot_gnt;
    logic [2*NUM_REQ-1:0] dbl_gnt;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
    assign rot     = NUM_REQ'({req, req} >> ptr);
    assign rot_gnt = rot & (~rot + 1'b1);
    assign dbl_gnt = {{NUM_REQ{1'b0}}, rot_gnt} << ptr;
    assign grant   = dbl_gnt[NUM_REQ-1:0] | dbl_gnt[2*NUM_REQ-1:NUM_REQ];

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ptr <= '0;
        else if (advance) ptr <= ptr_nxt;
    end

endmodule

// File: rtl/timestamp_snapshot_sequencer.sv
// Sequences timer configuration and 64-bit counter snapshots over a 16-bit timer bus.
// Define TSS_IRQ_ACK_EN to build the timer-interrupt acknowledge path.
module timestamp_snapshot_sequencer
    import timestamp_seq_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    timestamp_snapshot_sequencer_if.master bus
);
    localparam int         IDW     = $clog2(NUM_REQ);
    localparam logic [2:0] RD_LAST = 3'(SNAP_LATENCY - 3);

    seq_state_t         state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id, pend_id;
    logic               take_irq, take_cfg, take_req;
    logic [67:0]        cfg_lat;
    logic [47:0]        snap_acc;
    tmr_cmd_t           cmd;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (take_req),
        .grant   (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) grant_id = IDW'(i);
    end

`ifdef TSS_IRQ_ACK_EN
    assign take_irq      = (state == IDLE) && bus.tmr_irq;
    assign bus.irq_event = (state == IRQ_ACK);
`else
    logic unused_irq;
    assign unused_irq    = bus.tmr_irq;
    assign take_irq      = 1'b0;
    assign bus.irq_event = 1'b0;
`endif
    // A config wins over snapshot requests and leaves the arbiter pointer alone
    assign take_cfg = (state == IDLE) && !take_irq && bus.cfg_valid;
    assign take_req = (state == IDLE) && !take_irq && !bus.cfg_valid && (|bus.req_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd       = TMR_IDLE;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (take_irq)      state_nxt = IRQ_ACK;
                else if (take_cfg) state_nxt = CFG;
                else if (take_req) state_nxt = SNAP_WR;
            end
            CFG: begin
                cmd.cs      = 1'b1;
                cmd.write_n = 1'b0;
                cnt_nxt     = cnt + 3'd1;
                case (cnt)
                    3'd0: begin cmd.addr = ADDR_PERIOD0; cmd.data = cfg_lat[15:0];  end
                    3'd1: begin cmd.addr = ADDR_PERIOD1; cmd.data = cfg_lat[31:16]; end
                    3'd2: begin cmd.addr = ADDR_PERIOD2; cmd.data = cfg_lat[47:32]; end
                    3'd3: begin cmd.addr = ADDR_PERIOD3; cmd.data = cfg_lat[63:48]; end
                    default: begin
                        cmd.addr  = ADDR_CONTROL;
                        cmd.data  = {12'h0, cfg_lat[67:64]};
                        state_nxt = IDLE;
                    end
                endcase
            end
            SNAP_WR: begin
                cmd.cs      = 1'b1;
                cmd.write_n = 1'b0;
                cmd.addr    = ADDR_SNAP0;
                cnt_nxt     = '0;
                state_nxt   = SNAP_RD;
            end
            SNAP_RD: begin
                // Four read addresses, then one cycle to catch the last registered readdata
                cnt_nxt = cnt + 3'd1;
                if (cnt == RD_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cmd.cs   = 1'b1;
                    cmd.addr = ADDR_SNAP0 + {1'b0, cnt};
                end
            end
`ifdef TSS_IRQ_ACK_EN
            IRQ_ACK: begin
                cmd.cs      = 1'b1;
                cmd.write_n = 1'b0;
                cmd.addr    = ADDR_STATUS;
                state_nxt   = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.tmr_chipselect = cmd.cs;
    assign bus.tmr_write_n    = cmd.write_n;
    assign bus.tmr_address    = cmd.addr;
    assign bus.tmr_writedata  = cmd.data;
    assign bus.busy           = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.req_ready  <= '0;
            bus.cfg_ready  <= 1'b0;
            bus.snap_valid <= 1'b0;
            bus.snap_id    <= '0;
            bus.snap_value <= '0;
            snap_acc       <= '0;
            pend_id        <= '0;
            cfg_lat        <= '0;
        end else begin
            bus.req_ready  <= take_req ? grant : '0;
            bus.cfg_ready  <= take_cfg;
            bus.snap_valid <= 1'b0;
            if (take_cfg) cfg_lat <= {bus.cfg_ctrl, bus.cfg_period};
            if (take_req) pend_id <= grant_id;
            if (state == SNAP_RD) begin
                case (cnt)
                    3'd1: snap_acc[15:0]  <= bus.tmr_readdata;
                    3'd2: snap_acc[31:16] <= bus.tmr_readdata;
                    3'd3: snap_acc[47:32] <= bus.tmr_readdata;
                    RD_LAST: begin
                        bus.snap_value <= {bus.tmr_readdata, snap_acc};
                        bus.snap_id    <= pend_id;
                        bus.snap_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
